// File: rtl/input_port_buffer.sv
// Per-input-port VC buffer feeding the crossbar: one FIFO per VC, head-of-line
// presentation, per-VC packet state and credit return. Optional write-side
// packet-sequence checking is enabled with INPUT_PORT_BUFFER_PROTO_CHECK_EN.

module ipb_vc_fifo #(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_pop,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_state
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;

  logic [FLIT_W-1:0] r_mem [BUFFER_SIZE];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;
  logic              r_state;
  logic [1:0]        w_htype;

  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == CW'(BUFFER_SIZE));
  // Empty FIFO presents zero so the crossbar input is clean out of reset.
  assign o_flit  = o_valid ? r_mem[r_rptr] : '0;
  assign o_state = r_state;
  assign w_htype = r_mem[r_rptr][FLIT_W-1 -: 2];

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_wr)  r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      case ({i_wr, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Packet state follows the type of each flit leaving the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= 1'b0;
    end else if (i_pop) begin
      if (!r_state && w_htype == T_HEAD)      r_state <= 1'b1;
      else if (r_state && w_htype == T_TAIL)  r_state <= 1'b0;
    end
  end
endmodule

module input_port_buffer #(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  input  logic [$clog2(VC_NUM)-1:0]       vc_i,
  input  logic [FLIT_W-1:0]               flit_i,
  input  logic [VC_NUM-1:0]               rd_en_i,
  output logic [VC_NUM-1:0][FLIT_W-1:0]   flit_o,
  output logic [VC_NUM-1:0]               vc_valid_o,
  output logic [VC_NUM-1:0]               vc_head_o,
  output logic [VC_NUM-1:0]               vc_state_o,
  output logic                            credit_valid_o,
  output logic [$clog2(VC_NUM)-1:0]       credit_vc_o,
  output logic                            err_o
);
  localparam int VW = $clog2(VC_NUM);

  logic [VC_NUM-1:0] w_sel_oh;
  logic [VC_NUM-1:0] w_pop;
  logic              w_pop_any;
  logic [VW-1:0]     w_pop_idx;
  logic [VC_NUM-1:0] w_full;
  logic [VC_NUM-1:0] w_wr;
  logic [1:0]        w_type;
  logic              w_ovf;
  logic              w_viol;
  logic              w_accept;

  logic              r_credit_valid;
  logic [VW-1:0]     r_credit_vc;
  logic              r_err;

  // Lowest set grant wins; a grant on an empty VC simply does nothing.
  assign w_sel_oh  = rd_en_i & (~rd_en_i + {{(VC_NUM-1){1'b0}}, 1'b1});
  assign w_pop     = w_sel_oh & vc_valid_o;
  assign w_pop_any = |w_pop;

  always_comb begin
    w_pop_idx = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_pop[v]) w_pop_idx = VW'(v);
    end
  end

  assign w_type = flit_i[FLIT_W-1 -: 2];
  // A full FIFO still accepts when the same edge pops it.
  assign w_ovf  = valid_i & w_full[vc_i] & ~w_pop[vc_i];

`ifdef INPUT_PORT_BUFFER_PROTO_CHECK_EN
  logic [VC_NUM-1:0] r_wst;

  // Idle expects HEAD/HEADTAIL (type bits equal), active expects BODY/TAIL.
  assign w_viol = valid_i & (w_type[1] ^ w_type[0] ^ r_wst[vc_i]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wst <= '0;
    end else if (w_accept) begin
      if (!r_wst[vc_i] && w_type == 2'b00)      r_wst[vc_i] <= 1'b1;
      else if (r_wst[vc_i] && w_type == 2'b10)  r_wst[vc_i] <= 1'b0;
    end
  end
`else
  assign w_viol = 1'b0;
`endif

  assign w_accept = valid_i & ~w_ovf & ~w_viol;

  always_comb begin
    w_wr       = '0;
    w_wr[vc_i] = w_accept;
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    ipb_vc_fifo #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .FLIT_W      (FLIT_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr[g]),
      .i_data  (flit_i),
      .i_pop   (w_pop[g]),
      .o_flit  (flit_o[g]),
      .o_valid (vc_valid_o[g]),
      .o_full  (w_full[g]),
      .o_state (vc_state_o[g])
    );
    // HEAD (00) and HEADTAIL (11) are the types with equal bits.
    assign vc_head_o[g] = vc_valid_o[g] & (flit_o[g][FLIT_W-1] ~^ flit_o[g][FLIT_W-2]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit_valid <= 1'b0;
      r_credit_vc    <= '0;
      r_err          <= 1'b0;
    end else begin
      r_credit_valid <= w_pop_any;
      if (w_pop_any) r_credit_vc <= w_pop_idx;
      if (w_ovf | w_viol) r_err <= 1'b1;
    end
  end

  assign credit_valid_o = r_credit_valid;
  assign credit_vc_o    = r_credit_vc;
  assign err_o          = r_err;
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.

module tb_input_port_buffer;
  localparam int VC_NUM = 2;
  localparam int BS     = 8;
  localparam int FW     = 32;

  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] HT   = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  valid_i;
  logic [0:0]            vc_i;
  logic [FW-1:0]         flit_i;
  logic [1:0]            rd_en_i;
  logic [1:0][FW-1:0]    flit_o;
  logic [1:0]            vc_valid_o;
  logic [1:0]            vc_head_o;
  logic [1:0]            vc_state_o;
  logic                  credit_valid_o;
  logic [0:0]            credit_vc_o;
  logic                  err_o;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  input_port_buffer #(.VC_NUM(VC_NUM), .BUFFER_SIZE(BS), .FLIT_W(FW)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .vc_i           (vc_i),
    .flit_i         (flit_i),
    .rd_en_i        (rd_en_i),
    .flit_o         (flit_o),
    .vc_valid_o     (vc_valid_o),
    .vc_head_o      (vc_head_o),
    .vc_state_o     (vc_state_o),
    .credit_valid_o (credit_valid_o),
    .credit_vc_o    (credit_vc_o),
    .err_o          (err_o)
  );

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int p);
    return {t, 30'(p)};
  endfunction

  function automatic logic [1:0] ty(input int i);
    return (i == 0) ? HEAD : ((i == 7) ? TAIL : BODY);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [FW-1:0] mq [VC_NUM][$];
  logic          m_err;
  logic [1:0]    m_st;
  logic          m_cv;
  logic          m_cvc;
  int            m_sel;
  logic [FW-1:0] m_f;
  logic [1:0]    m_t;
  logic          m_drop;
`ifdef INPUT_PORT_BUFFER_PROTO_CHECK_EN
  logic [1:0]    m_wst;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) mq[v].delete();
      m_err = 1'b0; m_st = '0; m_cv = 1'b0; m_cvc = 1'b0;
`ifdef INPUT_PORT_BUFFER_PROTO_CHECK_EN
      m_wst = '0;
`endif
    end else begin
      m_sel = -1;
      for (int v = 0; v < VC_NUM; v++) if (rd_en_i[v] && m_sel < 0) m_sel = v;
      m_cv = 1'b0;
      if (m_sel >= 0 && mq[m_sel].size() > 0) begin
        m_f = mq[m_sel].pop_front();
        m_t = m_f[FW-1:FW-2];
        if (!m_st[m_sel] && m_t == HEAD)     m_st[m_sel] = 1'b1;
        else if (m_st[m_sel] && m_t == TAIL) m_st[m_sel] = 1'b0;
        m_cv  = 1'b1;
        m_cvc = m_sel[0];
      end
      if (valid_i) begin
        m_t = flit_i[FW-1:FW-2];
        m_drop = 1'b0;
`ifdef INPUT_PORT_BUFFER_PROTO_CHECK_EN
        if (!m_wst[vc_i] && (m_t == BODY || m_t == TAIL)) m_drop = 1'b1;
        if (m_wst[vc_i] && (m_t == HEAD || m_t == HT))    m_drop = 1'b1;
`endif
        if (mq[vc_i].size() >= BS) m_drop = 1'b1;
        if (m_drop) m_err = 1'b1;
        else begin
          mq[vc_i].push_back(flit_i);
`ifdef INPUT_PORT_BUFFER_PROTO_CHECK_EN
          if (!m_wst[vc_i] && m_t == HEAD)     m_wst[vc_i] = 1'b1;
          else if (m_wst[vc_i] && m_t == TAIL) m_wst[vc_i] = 1'b0;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int v = 0; v < VC_NUM; v++) begin
        logic [FW-1:0] ef;
        logic          ev;
        ev = (mq[v].size() > 0);
        ef = ev ? mq[v][0] : '0;
        chk("model flit_o", 64'(flit_o[v]), 64'(ef));
        chk("model vc_valid_o", 64'(vc_valid_o[v]), 64'(ev));
        chk("model vc_head_o", 64'(vc_head_o[v]),
            64'(ev && (ef[FW-1:FW-2] == HEAD || ef[FW-1:FW-2] == HT)));
        chk("model vc_state_o", 64'(vc_state_o[v]), 64'(m_st[v]));
      end
      chk("model credit_valid_o", 64'(credit_valid_o), 64'(m_cv));
      chk("model credit_vc_o", 64'(credit_vc_o), 64'(m_cvc));
      chk("model err_o", 64'(err_o), 64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [0:0] c, input logic [FW-1:0] f,
                      input logic [1:0] rd);
    valid_i = v; vc_i = c; flit_i = f; rd_en_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0; vc_i = '0; flit_i = '0; rd_en_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic fill_vc0();
    for (int i = 0; i < BS; i++) step(1'b1, 1'b0, mk(ty(i), 16 + i), 2'b00);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; vc_i = '0; flit_i = '0; rd_en_i = '0;
    #1 rst = 1'b0;
    #1 chk_on = 1'b1;
    idle(2);
    rst = 1'b1;

    // reset then idle
    idle(5);
    chk("rst vc_valid_o", 64'(vc_valid_o), 64'(2'b00));
    chk("rst credit_valid_o", 64'(credit_valid_o), 64'(0));
    chk("rst err_o", 64'(err_o), 64'(0));
    chk("rst vc_state_o", 64'(vc_state_o), 64'(2'b00));

    // HEAD/BODY/TAIL through VC1
    step(1'b1, 1'b1, mk(HEAD, 1), 2'b00);
    step(1'b1, 1'b1, mk(BODY, 2), 2'b00);
    step(1'b1, 1'b1, mk(TAIL, 3), 2'b00);
    chk("pkt head flit", 64'(flit_o[1]), 64'(32'h0000_0001));
    chk("pkt head flag", 64'(vc_head_o[1]), 64'(1));
    chk("pkt state0", 64'(vc_state_o[1]), 64'(0));
    step(1'b0, 1'b0, '0, 2'b10);
    chk("pkt body flit", 64'(flit_o[1]), 64'(32'h4000_0002));
    chk("pkt state1", 64'(vc_state_o[1]), 64'(1));
    chk("pkt credit1", 64'({credit_valid_o, credit_vc_o}), 64'(2'b11));
    step(1'b0, 1'b0, '0, 2'b10);
    chk("pkt tail flit", 64'(flit_o[1]), 64'(32'h8000_0003));
    chk("pkt state2", 64'(vc_state_o[1]), 64'(1));
    chk("pkt credit2", 64'({credit_valid_o, credit_vc_o}), 64'(2'b11));
    step(1'b0, 1'b0, '0, 2'b10);
    chk("pkt state3", 64'(vc_state_o[1]), 64'(0));
    chk("pkt empty", 64'(vc_valid_o[1]), 64'(0));
    chk("pkt credit3", 64'({credit_valid_o, credit_vc_o}), 64'(2'b11));
    idle(1);
    chk("pkt credit off", 64'({credit_valid_o, credit_vc_o}), 64'(2'b01));

    // overflow on a full VC0
    do_reset();
    fill_vc0();
    chk("ovf no err yet", 64'(err_o), 64'(0));
    step(1'b1, 1'b0, mk(HT, 'h99), 2'b00);
    chk("ovf err", 64'(err_o), 64'(1));
    for (int i = 0; i < BS; i++) begin
      chk("ovf order", 64'(flit_o[0]), 64'(mk(ty(i), 16 + i)));
      step(1'b0, 1'b0, '0, 2'b01);
      chk("ovf credit", 64'({credit_valid_o, credit_vc_o}), 64'(2'b10));
    end
    chk("ovf drained", 64'(vc_valid_o[0]), 64'(0));
    chk("ovf err sticky", 64'(err_o), 64'(1));

    // full VC0 with simultaneous read and write
    do_reset();
    fill_vc0();
    step(1'b1, 1'b0, mk(HT, 'h99), 2'b01);
    chk("fullrw err", 64'(err_o), 64'(0));
    chk("fullrw valid", 64'(vc_valid_o[0]), 64'(1));
    chk("fullrw credit", 64'(credit_valid_o), 64'(1));
    for (int i = 1; i < BS; i++) begin
      chk("fullrw order", 64'(flit_o[0]), 64'(mk(ty(i), 16 + i)));
      step(1'b0, 1'b0, '0, 2'b01);
    end
    chk("fullrw last", 64'(flit_o[0]), 64'(32'hC000_0099));
    step(1'b0, 1'b0, '0, 2'b01);
    chk("fullrw empty", 64'(vc_valid_o[0]), 64'(0));
    chk("fullrw state", 64'(vc_state_o[0]), 64'(0));

    // read of an empty VC on the write cycle, then multi-hot grant
    do_reset();
    step(1'b1, 1'b1, mk(HT, 4), 2'b00);
    step(1'b0, 1'b0, '0, 2'b10);
    chk("mh setup cvc", 64'(credit_vc_o), 64'(1));
    step(1'b1, 1'b0, mk(HT, 5), 2'b11);
    chk("mh no credit", 64'(credit_valid_o), 64'(0));
    chk("mh stored", 64'(vc_valid_o[0]), 64'(1));
    chk("mh head flag", 64'(vc_head_o[0]), 64'(1));
    step(1'b0, 1'b0, '0, 2'b11);
    chk("mh credit", 64'({credit_valid_o, credit_vc_o}), 64'(2'b10));
    chk("mh state", 64'(vc_state_o[0]), 64'(0));
    chk("mh popped", 64'(vc_valid_o[0]), 64'(0));

    // write-side sequence check, then asynchronous reset mid-packet
    do_reset();
    step(1'b1, 1'b1, mk(BODY, 7), 2'b00);
`ifdef INPUT_PORT_BUFFER_PROTO_CHECK_EN
    chk("proto err", 64'(err_o), 64'(1));
    chk("proto dropped", 64'(vc_valid_o[1]), 64'(0));
`else
    chk("noproto err", 64'(err_o), 64'(0));
    chk("noproto stored", 64'(vc_valid_o[1]), 64'(1));
`endif
    step(1'b1, 1'b0, mk(HEAD, 8), 2'b00);
    step(1'b1, 1'b0, mk(BODY, 9), 2'b00);
    step(1'b0, 1'b0, '0, 2'b01);
    chk("mid state", 64'(vc_state_o[0]), 64'(1));
    valid_i = 1'b1; vc_i = 1'b0; flit_i = mk(TAIL, 10);
    #2 rst = 1'b0;
    #1;
    chk("arst vc_valid_o", 64'(vc_valid_o), 64'(0));
    chk("arst vc_state_o", 64'(vc_state_o), 64'(0));
    chk("arst credit", 64'({credit_valid_o, credit_vc_o}), 64'(0));
    chk("arst err_o", 64'(err_o), 64'(0));
    chk("arst flit_o", 64'(flit_o), 64'(0));
    chk("arst vc_head_o", 64'(vc_head_o), 64'(0));
    valid_i = 1'b0; flit_i = '0;
    idle(2);
    rst = 1'b1;
    idle(2);
    chk("post rst credit", 64'(credit_valid_o), 64'(0));
    chk("post rst empty", 64'(vc_valid_o), 64'(0));

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
